// File: rtl/nios_system_div_pkg.sv
// Shared types and constants for the Nios II M-stage iterative divider.
package nios_system_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = 5;
    localparam logic [DIV_WIDTH-1:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

endpackage

// File: rtl/nios_system_nios2_qsys_0_div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, try to subtract the divisor.
module nios_system_nios2_qsys_0_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         dvd_bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_bit_o
);

    logic [W:0] shifted;
    logic [W:0] trial;

    assign shifted = {rem_i, dvd_bit_i};
    assign trial   = shifted - {1'b0, dvs_i};

    // A clear borrow bit means the trial subtraction did not go negative.
    assign q_bit_o = ~trial[W];
    assign rem_o   = q_bit_o ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/nios_system_nios2_qsys_0_div_cell.sv
// Iterative 32-bit signed/unsigned divider: magnitude restoring division, then sign fix.
module nios_system_nios2_qsys_0_div_cell #(
    parameter int DIV_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] M_div_src1,
    input  logic [DIV_WIDTH-1:0] M_div_src2,
    input  logic                 M_div_signed,
    input  logic                 M_div_start,
    output logic                 M_div_busy,
    output logic                 M_div_done,
    output logic [DIV_WIDTH-1:0] M_div_quotient,
    output logic [DIV_WIDTH-1:0] M_div_remainder,
    output logic [1:0]           M_div_state
);

    import nios_system_div_pkg::*;

    div_state_t             state_q;
    logic [DIV_CNT_W-1:0]   cnt_q;
    logic [DIV_WIDTH-1:0]   dvd_q;
    logic [DIV_WIDTH-1:0]   dvs_q;
    logic [DIV_WIDTH-1:0]   rem_q;
    logic [DIV_WIDTH-1:0]   src1_q;
    logic [DIV_WIDTH-1:0]   quot_q;
    logic [DIV_WIDTH-1:0]   remd_q;
    logic                   neg_quot_q;
    logic                   neg_rem_q;
    logic                   div_zero_q;

    logic                   src1_neg;
    logic                   src2_neg;
    logic [DIV_WIDTH-1:0]   src1_mag;
    logic [DIV_WIDTH-1:0]   src2_mag;
    logic [DIV_WIDTH-1:0]   rem_step;
    logic                   q_bit;
    logic [DIV_WIDTH-1:0]   dvd_step;
    logic [DIV_WIDTH-1:0]   quot_d;
    logic [DIV_WIDTH-1:0]   rem_d;

    assign src1_neg = M_div_signed & M_div_src1[DIV_WIDTH-1];
    assign src2_neg = M_div_signed & M_div_src2[DIV_WIDTH-1];
    assign src1_mag = src1_neg ? -M_div_src1 : M_div_src1;
    assign src2_mag = src2_neg ? -M_div_src2 : M_div_src2;

    nios_system_nios2_qsys_0_div_step #(
        .W (DIV_WIDTH)
    ) u_step (
        .rem_i     (rem_q),
        .dvd_bit_i (dvd_q[DIV_WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (rem_step),
        .q_bit_o   (q_bit)
    );

    // The dividend register doubles as the quotient register: bits shift out the top, quotient bits in the bottom.
    assign dvd_step = {dvd_q[DIV_WIDTH-2:0], q_bit};

    // Sign fix on the last step's result; divide-by-zero overrides the magnitude path.
    assign quot_d = div_zero_q ? DIV_BY_ZERO_Q : (neg_quot_q ? -dvd_step : dvd_step);
    assign rem_d  = div_zero_q ? src1_q        : (neg_rem_q  ? -rem_step : rem_step);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            src1_q     <= '0;
            quot_q     <= '0;
            remd_q     <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (M_div_start) begin
                        dvd_q      <= src1_mag;
                        dvs_q      <= src2_mag;
                        rem_q      <= '0;
                        src1_q     <= M_div_src1;
                        neg_quot_q <= src1_neg ^ src2_neg;
                        neg_rem_q  <= src1_neg;
                        div_zero_q <= (M_div_src2 == '0);
                        cnt_q      <= DIV_CNT_W'(DIV_WIDTH - 1);
                        state_q    <= ITER;
                    end
                end
                ITER: begin
                    rem_q <= rem_step;
                    dvd_q <= dvd_step;
                    if (cnt_q == '0) begin
                        quot_q  <= quot_d;
                        remd_q  <= rem_d;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign M_div_busy      = (state_q != IDLE);
    assign M_div_done      = (state_q == DONE);
    assign M_div_quotient  = quot_q;
    assign M_div_remainder = remd_q;
    assign M_div_state     = state_q;

endmodule

// File: tb/tb_nios_system_nios2_qsys_0_div_cell.sv
// Self-checking bench for the iterative divider: cycle-accurate timing plus a reference-model scoreboard.
module tb_nios_system_nios2_qsys_0_div_cell;

    logic        clk;
    logic        reset;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        sgn;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic [31:0] remd;
    logic [1:0]  state;

    logic [63:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    nios_system_nios2_qsys_0_div_cell #(
        .DIV_WIDTH (32)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .M_div_src1      (src1),
        .M_div_src2      (src2),
        .M_div_signed    (sgn),
        .M_div_start     (start),
        .M_div_busy      (busy),
        .M_div_done      (done),
        .M_div_quotient  (quot),
        .M_div_remainder (remd),
        .M_div_state     (state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // Reference model: truncating division, remainder follows the dividend sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (s) begin
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                q = 32'h80000000;
                r = 32'd0;
            end else begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    // Driver: present an operation and record its expected result.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        src1  = a;
        src2  = b;
        sgn   = s;
        start = 1'b1;
        exp_q.push_back(ref_div(a, b, s));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        src1  = 32'd0;
        src2  = 32'd0;
        sgn   = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++;
        if (quot !== 32'd0) begin n_fail++; $display("FAIL reset_quot: got %h, required 0", quot); end
        n_checks++;
        if (remd !== 32'd0) begin n_fail++; $display("FAIL reset_rem: got %h, required 0", remd); end
        n_checks++;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, required 0", state); end
    endtask

    // One operation started in cycle 0; checks busy/done every cycle and the result in cycle 33.
    task automatic test_single_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [63:0] exp;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy: got %b, required 0", name, busy); end
        start_op(a, b, s);
        for (int c = 1; c <= 33; c++) begin
            tick();
            if (c == 1) start = 1'b0;
            n_checks++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy c%0d: got %b, required 1", name, c, busy); end
            n_checks++;
            if (done !== (c == 33)) begin n_fail++; $display("FAIL %s_done c%0d: got %b, required %b", name, c, done, (c == 33)); end
            if (c == 33) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s_scoreboard: got done with empty queue, required a pending result", name);
                end else begin
                    exp = exp_q.pop_front();
                    if ({quot, remd} !== exp) begin
                        n_fail++;
                        $display("FAIL %s_result: got q=%h r=%h, required q=%h r=%h", name, quot, remd, exp[63:32], exp[31:0]);
                    end
                end
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [63:0] exp;
        tick();
        start_op(32'd1000, 32'd9, 1'b0);
        for (int c = 1; c <= 35; c++) begin
            tick();
            if (c == 1 || c == 6 || c == 34) start = 1'b0;
            if (c == 6) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL swb_busy c6: got %b, required 1", busy); end
            end
            if (c == 33) begin
                n_checks++;
                if (done !== 1'b1) begin n_fail++; $display("FAIL swb_done c33: got %b, required 1", done); end
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL swb_scoreboard: got empty queue, required a pending result");
                end else begin
                    exp = exp_q.pop_front();
                    if ({quot, remd} !== exp) begin
                        n_fail++;
                        $display("FAIL swb_result: got q=%h r=%h, required q=%h r=%h", quot, remd, exp[63:32], exp[31:0]);
                    end
                end
            end
            if (c == 34 || c == 35) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL swb_idle c%0d: got busy=%b, required 0", c, busy); end
                n_checks++;
                if (done !== 1'b0) begin n_fail++; $display("FAIL swb_nodone c%0d: got %b, required 0", c, done); end
            end
            if (c == 35) begin
                n_checks++;
                if (quot !== 32'd111 || remd !== 32'd1) begin
                    n_fail++;
                    $display("FAIL swb_held: got q=%h r=%h, required q=%h r=%h", quot, remd, 32'd111, 32'd1);
                end
            end
            // Starts with different operands while busy must be ignored.
            if (c == 5 || c == 33) begin
                src1  = 32'd55;
                src2  = 32'd5;
                start = 1'b1;
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] exp;
        tick();
        start_op(32'hDEADBEEF, 32'h1234, 1'b0);
        for (int c = 1; c <= 46; c++) begin
            tick();
            if (c == 1 || c == 13) start = 1'b0;
            if (c == 10) reset = 1'b1;
            if (c == 11) begin
                n_checks++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rmid_flags: got busy=%b done=%b, required 0 0", busy, done);
                end
                n_checks++;
                if (quot !== 32'd0 || remd !== 32'd0) begin
                    n_fail++;
                    $display("FAIL rmid_outputs: got q=%h r=%h, required 0 0", quot, remd);
                end
                n_checks++;
                if (state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d, required 0", state); end
                reset = 1'b0;
                exp_q.delete();
            end
            if (c == 12) start_op(32'd500, 32'd3, 1'b0);
            if (c >= 13 && c <= 45) begin
                n_checks++;
                if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy c%0d: got %b, required 1", c, busy); end
                n_checks++;
                if (done !== (c == 45)) begin n_fail++; $display("FAIL rmid_done c%0d: got %b, required %b", c, done, (c == 45)); end
            end
            if (c == 45) begin
                n_checks++;
                if (exp_q.size() != 1) begin
                    n_fail++;
                    $display("FAIL rmid_scoreboard: got %0d pending, required 1", exp_q.size());
                    exp_q.delete();
                end else begin
                    exp = exp_q.pop_front();
                    if ({quot, remd} !== exp) begin
                        n_fail++;
                        $display("FAIL rmid_result: got q=%h r=%h, required q=%h r=%h", quot, remd, exp[63:32], exp[31:0]);
                    end
                end
            end
            if (c == 46) begin
                n_checks++;
                if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_idle: got %b, required 0", busy); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h80000000;
                1: a = 32'hFFFFFFFF;
                2: a = 32'd0;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                2: b = 32'd1;
                3: b = $urandom_range(1, 255);
                4: b = -($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            s = 1'($urandom_range(0, 1));
            test_single_op("b2b", a, b, s);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_op("udiv_100_7",  32'd100,        32'd7,          1'b0);
        test_single_op("sdiv_m7_2",   32'hFFFFFFF9,   32'd2,          1'b1);
        test_single_op("sdiv_7_m2",   32'd7,          32'hFFFFFFFE,   1'b1);
        test_single_op("udiv_zero",   32'h12345678,   32'd0,          1'b0);
        test_single_op("sdiv_zero",   32'hFFFFFFF0,   32'd0,          1'b1);
        test_single_op("sdiv_ovf",    32'h80000000,   32'hFFFFFFFF,   1'b1);
        test_single_op("udiv_max_1",  32'hFFFFFFFF,   32'd1,          1'b0);
        test_single_op("udiv_big",    32'hFFFFFFF9,   32'd2,          1'b0);
        test_start_while_busy();
        test_reset_mid();
        test_back_to_back();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_system_nios2_qsys_0_div_cell.md
# nios_system_nios2_qsys_0_div_cell

Iterative 32-bit integer divider that complements the pipelined multiply cell in the Nios II M-stage datapath. It serves `div`/`divu`: it accepts a dividend/divisor pair on a single-cycle start strobe and runs a radix-2 restoring division, one quotient bit per cycle. It returns quotient and remainder with a one-cycle done pulse. The CPU control logic stalls on `M_div_busy`.

## Interface
Parameters:
- `DIV_WIDTH`, 32: operand/result width; only 32 is verified.

Ports:
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `M_div_src1`  in  32  dividend.
- `M_div_src2`  in  32  divisor.
- `M_div_signed`  in  1  1 = two's-complement (`div`), 0 = unsigned (`divu`).
- `M_div_start`  in  1  start strobe; sampled only in IDLE.
- `M_div_busy`  out  1  high while an operation is in flight (state != IDLE).
- `M_div_done`  out  1  one-cycle pulse; results are valid in the same cycle.
- `M_div_quotient`  out  32  registered quotient, held until the next accepted start.
- `M_div_remainder`  out  32  registered remainder, held until the next accepted start.

## Operation
- States: IDLE, ITER, DONE. Reset goes to IDLE. All outputs reset to 0.
- IDLE with `M_div_start`=1:
  - Capture operand signs (only when signed).
  - Capture |src1| into the dividend shift register and |src2| into the divisor register.
  - Clear the partial remainder. Set the step counter to 31.
  - Go to ITER.
- IDLE with `M_div_start`=0: remain in IDLE.
- ITER, one restoring step per cycle:
  - `trial = {rem[31:0], dvd[31]} - {1'b0, dvs}` (33-bit).
  - If `trial` ≥ 0: `rem = trial[31:0]` and the quotient bit is 1. Otherwise `rem` is the shifted value and the quotient bit is 0.
  - Shift the quotient bit into `dvd[0]`.
  - Counter at 0 → DONE. Otherwise decrement.
- ITER→DONE transition (sign fix, registered into the outputs):
  - Quotient is negated iff signed and the operand signs differ.
  - Remainder is negated iff signed and the dividend is negative. Quotient truncates toward zero; the remainder takes the dividend's sign.
- DONE: `M_div_done`=1 for exactly one cycle, then IDLE. A start seen in DONE is ignored.
- Start while busy (ITER/DONE): ignored and has no effect on the operation in flight.
- Divide by zero (either mode): quotient = 0xFFFFFFFF, remainder = `M_div_src1`. Latency is unchanged. The override is applied in the sign-fix step.
- Signed overflow 0x80000000 / -1: quotient = 0x80000000, remainder = 0. This falls out of the magnitude path; there is no special case.
- `reset` mid-operation:
  - Next cycle the state is IDLE.
  - `M_div_busy`, `M_div_done`, `M_div_quotient` and `M_div_remainder` are all 0.
  - The partial result is discarded.

## Timing
- Start sampled high in IDLE in cycle 0.
- ITER occupies cycles 1–32. DONE is cycle 33.
- `M_div_busy` is high in cycles 1–33 inclusive and low in cycle 0 and cycle 34.
- `M_div_done` is high in cycle 33 only. Quotient and remainder are valid from cycle 33 and held.
- Earliest next accepted start: cycle 34. Throughput is 1 division per 34 cycles.
- No combinational path from any input to any output.

## Structure
- Package `nios_system_div_pkg`:
  - `div_state_t` enum (IDLE, ITER, DONE).
  - `DIV_WIDTH` localparam.
  - `DIV_CNT_W` = 5.
  - `DIV_BY_ZERO_Q` = 32'hFFFFFFFF.
- Sub-module `nios_system_nios2_qsys_0_div_step`: purely combinational restoring step.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once in the top level.
- Top level contains the FSM, counter, operand and sign registers, and the sign-fix/override logic.

## Test plan
- **Unsigned 100/7**, start in cycle 0 → busy in cycles 1–33, done in cycle 33; q=14, r=2.
- **Signed -7/2** (0xFFFFFFF9 / 2) → q=0xFFFFFFFD, r=0xFFFFFFFF; signed 7/-2 → q=0xFFFFFFFD, r=1.
- **Divide by zero**:
  - unsigned 0x12345678/0 → q=0xFFFFFFFF, r=0x12345678;
  - signed 0xFFFFFFF0/0 → q=0xFFFFFFFF, r=0xFFFFFFF0.
- **Signed overflow** 0x80000000 / 0xFFFFFFFF → q=0x80000000, r=0; unsigned 0xFFFFFFFF/1 → q=0xFFFFFFFF, r=0.
- **Robustness**:
  - Start re-asserted in cycles 5 and 33 → ignored; the single result appears at cycle 33.
  - `reset` in cycle 10 → cycle 11 has busy=0, done=0, q=r=0.
  - A fresh start in cycle 12 completes at cycle 45.
- **Randomized back-to-back ops** (start in each cycle 34k) vs a reference model → all q/r match, including the sign and zero corners.
